// File: rtl/shift_add_mult_8bit_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the fixed operand width / iteration count.
package shift_add_mult_8bit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } mult_state_t;

   localparam int MULT_WIDTH = 8;
   localparam int MULT_ITERS = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, the building block of rca_8bit.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   // Sum and carry of three input bits.
   always_comb begin
      s  = a ^ b ^ ci;
      co = (a & b) | (ci & (a ^ b));
   end

endmodule

// File: rtl/rca_8bit.sv
// 8-bit ripple-carry adder built from a chain of full_adder cells.
module rca_8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   logic [8:0] carry;

   assign carry[0] = cin;
   assign cout     = carry[8];

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_bit
         full_adder u_fa (
            .a  (a[gi]),
            .b  (b[gi]),
            .ci (carry[gi]),
            .s  (sum[gi]),
            .co (carry[gi+1])
         );
      end
   endgenerate

endmodule

// File: rtl/shift_add_mult_8bit.sv
// Sequential 8x8 unsigned multiplier: one shift-and-add step per clock
// for eight clocks, using rca_8bit as the accumulator adder, with a
// start/busy/done handshake to the host.
module shift_add_mult_8bit
   import shift_add_mult_8bit_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH,
   parameter int CNT_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   mult_state_t          state_reg;
   logic [WIDTH-1:0]     m_reg;
   logic [2*WIDTH-1:0]   p_reg;
   logic [2*WIDTH-1:0]   p_next;
   logic [2*WIDTH-1:0]   product_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic [WIDTH-1:0]     add_sum;
   logic                 add_cout;

   // Accumulate the multiplicand into the high half of the partial product.
   rca_8bit u_rca (
      .a    (p_reg[2*WIDTH-1:WIDTH]),
      .b    (m_reg),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // One iteration: add when the multiplier LSB is set, then shift right
   // with the adder carry landing in the top bit.
   always_comb begin
      p_next = {1'b0, p_reg[2*WIDTH-1:1]};
      if (p_reg[0]) begin
         p_next = {add_cout, add_sum, p_reg[WIDTH-1:1]};
      end
   end

   // Control FSM, iteration counter, shift register and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         m_reg       <= '0;
         p_reg       <= '0;
         cnt_reg     <= '0;
         product_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  m_reg     <= a;
                  p_reg     <= {{WIDTH{1'b0}}, b};
                  cnt_reg   <= '0;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               p_reg   <= p_next;
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == CNT_W'(MULT_ITERS - 1)) begin
                  product_reg <= p_next;
                  state_reg   <= DONE;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign busy    = (state_reg != IDLE);
   assign done    = (state_reg == DONE);
   assign product = product_reg;

endmodule

// File: tb/tb_shift_add_mult_8bit.sv
// Self-checking bench for shift_add_mult_8bit: directed cases followed
// by random operands, compared against plain a*b arithmetic.
module tb_shift_add_mult_8bit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  a = 8'h00;
   logic [7:0]  b = 8'h00;
   logic        busy;
   logic        done;
   logic [15:0] product;

   int errors = 0;
   int checks = 0;
   logic [15:0] prev_exp = 16'h0000;

   shift_add_mult_8bit dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One multiply from a single start pulse; optionally re-pulses start
   // with other operands while RUN and while DONE.
   task automatic do_mult(input logic [7:0] x, input logic [7:0] y,
                          input bit repulse, input string tag);
      logic [15:0] exp;
      logic [15:0] got;
      int busy_n;
      int done_n;
      int lat;
      exp = {8'h00, x} * {8'h00, y};
      @(negedge clk);
      a = x; b = y; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      busy_n = 0; done_n = 0; lat = -1; got = 16'h0000;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (lat < 0) begin
               lat = k;
               got = product;
            end
         end
         if (k == 1) chk({tag, "_hold"}, int'(product), int'(prev_exp));
         if (repulse) begin
            if (k == 3 || k == 9) begin
               start = 1'b1; a = 8'd9; b = 8'd9;
            end else if (k == 4 || k == 10) begin
               start = 1'b0;
            end
         end
      end
      chk({tag, "_product"}, int'(got), int'(exp));
      chk({tag, "_latency"}, lat, 9);
      chk({tag, "_done_count"}, done_n, 1);
      chk({tag, "_busy_cycles"}, busy_n, 9);
      chk({tag, "_idle_after"}, int'(busy), 0);
      chk({tag, "_product_held"}, int'(product), int'(exp));
      prev_exp = exp;
      $display("op %s a=%0d b=%0d product=%0d expected=%0d", tag, x, y, got, exp);
   endtask

   initial begin
      int last_done;
      int ndone;
      int stray;

      // Reset state
      #12;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_product", int'(product), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_product", int'(product), 0);

      // Directed multiplies
      do_mult(8'd13, 8'd11, 1'b0, "basic");
      do_mult(8'hFF, 8'hFF, 1'b0, "carry");
      do_mult(8'h00, 8'hC8, 1'b0, "zero_a");
      do_mult(8'h80, 8'h02, 1'b0, "pow2");
      do_mult(8'hC8, 8'h00, 1'b0, "zero_b");
      do_mult(8'd5, 8'd6, 1'b1, "start_busy");

      // Reset in the middle of an operation
      @(negedge clk);
      a = 8'd200; b = 8'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_product", int'(product), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) stray++;
      end
      chk("midrst_no_done", stray, 0);
      prev_exp = 16'h0000;
      $display("op midrst a=200 b=3 aborted");
      do_mult(8'd3, 8'd7, 1'b0, "after_rst");

      // Back-to-back with start held high
      @(negedge clk);
      a = 8'd16; b = 8'd16; start = 1'b1;
      @(posedge clk);
      last_done = -1; ndone = 0;
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (last_done < 0) chk("b2b_first_latency", k, 9);
            else chk("b2b_spacing", k - last_done, 10);
            last_done = k;
            chk("b2b_product", int'(product), 16'h0100);
         end else if (last_done >= 0) begin
            chk("b2b_stable", int'(product), 16'h0100);
         end
      end
      chk("b2b_done_count", ndone, 3);
      start = 1'b0;
      repeat (12) @(negedge clk);
      prev_exp = 16'h0100;
      $display("op b2b a=16 b=16 dones=%0d product=%0d", ndone, product);

      // Random operands
      for (int i = 0; i < 20; i++) begin
         logic [7:0] rx;
         logic [7:0] ry;
         rx = 8'($urandom_range(0, 255));
         ry = 8'($urandom_range(0, 255));
         do_mult(rx, ry, 1'b0, $sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL timeout reached observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/shift_add_mult_8bit.md
Name: shift_add_mult_8bit

Overview:
- Sequential 8x8 unsigned multiplier.
- Runs one shift-and-add iteration per clock for 8 clocks.
- Sits directly upstream of the existing 8-bit ripple-carry adder. Each cycle it drives the adder's operands (partial-product high byte and multiplicand) and consumes the adder's sum/cout.
- Provides a start/busy/done handshake to its host.

Parameters:
- WIDTH, 8, operand width. Fixed to 8 because it must match rca_8bit; other values are unsupported.
- CNT_W, 4, iteration counter width (holds 0..8).

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled only in IDLE
- a  input  8  multiplicand; captured on the accepting edge
- b  input  8  multiplier; captured on the accepting edge
- busy  output  1  high in RUN and DONE; low in IDLE
- done  output  1  one-cycle pulse; high in DONE
- product  output  16  unsigned a*b; registered, valid from done and held until the next accepted start

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, busy=0, done=0, product=16'h0000, counter=0, internal registers cleared.
  - Reset mid-operation aborts the multiply. No done is produced, and product returns to 0.
  - Release of reset takes effect on the next rising edge.
- Internal registers: M[7:0] (multiplicand), P[15:0] (partial product / multiplier shift register), cnt[CNT_W-1:0].
- State machine (IDLE, RUN, DONE):
  - IDLE: on an edge with start=1, load M<=a, P<={8'h00,b}, cnt<=0, go to RUN. With start=0, stay in IDLE.
  - RUN: each edge performs one iteration and increments cnt. On the edge where cnt==7 (the 8th iteration), go to DONE and load product with the final P value.
  - DONE: lasts exactly one cycle (done=1), then return to IDLE unconditionally.
- Iteration, using the adder with operand A=P[15:8], operand B=M, cin=0:
  - If P[0]==1: P <= {cout, sum[7:0], P[7:1]}.
  - If P[0]==0: P <= {1'b0, P[15:1]}. The adder output is ignored.
  - The adder carry must be retained as bit 15. Dropping cout corrupts the result; 255*255 exercises this.
- Adder connection: the adder is combinational (ripple), so the adder path from P/M to the P register must close in one clk period. No extra pipeline stage is inserted.
- Latency:
  - start sampled high at edge E0.
  - Iterations occur on edges E1..E8.
  - done and product are valid in the cycle following E8, then done falls at E9.
  - Minimum start-to-start spacing is 10 cycles.
- start while busy (RUN or DONE): ignored, and the a/b inputs are not captured. start held high continuously restarts on the first edge back in IDLE.
- product holds its value through IDLE and RUN of a subsequent operation, changing only on entry to DONE or on reset.
- Boundary cases:
  - a=0 or b=0 gives product 0.
  - The maximum 255*255=65025 fits in 16 bits. Overflow is impossible.
- busy = (state != IDLE); done = (state == DONE). Both are decoded from registered state and are glitch-free relative to clk.

Decomposition:
- Shared package holds:
  - the state encoding constants IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - MULT_WIDTH=8;
  - MULT_ITERS=8.
- One sub-module instance: the existing rca_8bit (which itself uses full_adder), used as the per-cycle accumulator adder. No other sub-modules.
- The FSM, counter and shift register live in shift_add_mult_8bit.

Test Plan:
- Basic multiply: reset, then a=8'd13, b=8'd11, start pulse -> busy=1 for 9 cycles; done pulses once, 9 cycles after the start edge; product=16'h008F (143).
- Carry retention: a=8'hFF, b=8'hFF -> product=16'hFE01 (65025).
- Zero operand: a=8'h00, b=8'hC8 -> product=16'h0000. Then a=8'h80, b=8'h02 -> product=16'h0100.
- Start while busy: start a=5, b=6. Re-pulse start with a=9, b=9 during RUN and again in DONE -> both ignored; product=16'h001E; exactly one done.
- Reset mid-op: start a=200, b=3; assert rst_n low at iteration 4 -> busy, done and product go to 0 immediately without waiting for clk; no done after release; next op a=3, b=7 -> product=16'h0015.
- Back-to-back: hold start high with a=16, b=16 -> product=16'h0100; done every 10 cycles; product is stable between done pulses.
